// File: rtl/toggle_pattern_gen_pkg.sv
// Shared definitions for the toggle pattern generator: FSM state encoding
// and the default width of every internal counter.
package toggle_pattern_gen_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/toggle_pattern_gen_toggle_div.sv
// One pattern channel: a modulo-DIV counter that inverts the output bit
// each time the counter wraps. clr has priority over en so a new run always
// starts from a known phase.
module toggle_div #(
    parameter int DIV   = 5,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic q
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             q_reg;

    // Counter and toggle flop; the wrap and the inversion happen on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            q_reg   <= 1'b0;
        end else if (clr) begin
            cnt_reg <= '0;
            q_reg   <= 1'b0;
        end else if (en) begin
            if (cnt_reg == TERM) begin
                cnt_reg <= '0;
                q_reg   <= ~q_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/toggle_pattern_gen.sv
// Four-channel toggle pattern generator. A start request launches a run of
// RUN_CYCLES cycles during which each channel toggles every DIV_x cycles;
// a normal finish pulses done, an abort (stop) clears the pattern.
module toggle_pattern_gen
    import toggle_pattern_gen_pkg::*;
#(
    parameter int DIV_A      = 5,
    parameter int DIV_B      = 10,
    parameter int DIV_C      = 15,
    parameter int DIV_D      = 20,
    parameter int RUN_CYCLES = 100,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0]   RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    // Divider values packed so the channel instances can be generated in a loop.
    localparam logic [4*CNT_W-1:0] DIV_VEC  = {CNT_W'(DIV_D), CNT_W'(DIV_C),
                                               CNT_W'(DIV_B), CNT_W'(DIV_A)};

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
    logic             ch_clr;
    logic             ch_en;
    logic [3:0]       pat;

    // State and run-length counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            run_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            run_cnt_reg <= run_cnt_next;
        end
    end

    // Next-state logic; stop dominates start, and start outside IDLE is ignored.
    always_comb begin
        state_next   = state_reg;
        run_cnt_next = run_cnt_reg;
        ch_clr       = 1'b0;
        ch_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next   = RUN;
                    run_cnt_next = '0;
                    ch_clr       = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next   = IDLE;
                    run_cnt_next = '0;
                    ch_clr       = 1'b1;
                end else begin
                    ch_en = 1'b1;
                    if (run_cnt_reg == RUN_LAST) begin
                        state_next   = DONE;
                        run_cnt_next = '0;
                    end else begin
                        run_cnt_next = run_cnt_reg + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            toggle_div #(
                .DIV   (int'(DIV_VEC[gi*CNT_W +: CNT_W])),
                .CNT_W (CNT_W)
            ) u_div (
                .clk (clk),
                .rst (rst),
                .clr (ch_clr),
                .en  (ch_en),
                .q   (pat[gi])
            );
        end
    endgenerate

    assign a    = pat[0];
    assign b    = pat[1];
    assign c    = pat[2];
    assign d    = pat[3];
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_toggle_pattern_gen.sv
// Bench for toggle_pattern_gen: a default-parameter instance and a small
// instance exercising DIV=1 and a short run, both driven by the same inputs
// and compared every cycle against a cycle-count reference model.
module tb_toggle_pattern_gen;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic stop;

    logic a0, b0, c0, d0, busy0, done0;
    logic a1, b1, c1, d1, busy1, done1;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: 0 idle, 1 run, 2 done.
    int         div_tab [2][4] = '{'{5, 10, 15, 20}, '{1, 2, 3, 7}};
    int         run_tab [2]    = '{100, 9};
    int         m_mode  [2];
    int         m_n     [2];
    logic [3:0] m_pat   [2];

    always #5 clk = ~clk;

    toggle_pattern_gen u_dut0 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .a     (a0),
        .b     (b0),
        .c     (c0),
        .d     (d0),
        .busy  (busy0),
        .done  (done0)
    );

    toggle_pattern_gen #(
        .DIV_A      (1),
        .DIV_B      (2),
        .DIV_C      (3),
        .DIV_D      (7),
        .RUN_CYCLES (9),
        .CNT_W      (4)
    ) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .a     (a1),
        .b     (b1),
        .c     (c1),
        .d     (d1),
        .busy  (busy1),
        .done  (done1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_mode[u] = 0;
            m_n[u]    = 0;
            m_pat[u]  = 4'b0;
        end
    endtask

    // Channel value = parity of completed DIV periods since the run began.
    task automatic model_edge(input int u, input logic s, input logic p);
        case (m_mode[u])
            0: begin
                if (s && !p) begin
                    m_mode[u] = 1;
                    m_n[u]    = 0;
                    m_pat[u]  = 4'b0;
                end
            end
            1: begin
                if (p) begin
                    m_mode[u] = 0;
                    m_pat[u]  = 4'b0;
                end else begin
                    m_n[u]++;
                    for (int ch = 0; ch < 4; ch++)
                        m_pat[u][ch] = ((m_n[u] / div_tab[u][ch]) % 2) == 1;
                    if (m_n[u] == run_tab[u])
                        m_mode[u] = 2;
                end
            end
            default: m_mode[u] = 0;
        endcase
    endtask

    task automatic check_all();
        check_val("u0_pat",  {28'd0, d0, c0, b0, a0}, {28'd0, m_pat[0]});
        check_val("u0_busy", {31'd0, busy0}, {31'd0, m_mode[0] == 1});
        check_val("u0_done", {31'd0, done0}, {31'd0, m_mode[0] == 2});
        check_val("u1_pat",  {28'd0, d1, c1, b1, a1}, {28'd0, m_pat[1]});
        check_val("u1_busy", {31'd0, busy1}, {31'd0, m_mode[1] == 1});
        check_val("u1_done", {31'd0, done1}, {31'd0, m_mode[1] == 2});
    endtask

    // One clock: drive inputs after a falling edge, advance the model at the
    // rising edge, compare at the next falling edge.
    task automatic step(input logic s, input logic p);
        start = s;
        stop  = p;
        @(posedge clk);
        model_edge(0, s, p);
        model_edge(1, s, p);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        step(1'b0, 1'b0);
        $display("reset: outputs idle");

        // Uninterrupted run, followed by idle hold of the final pattern.
        step(1'b1, 1'b0);
        repeat (110) step(1'b0, 1'b0);
        $display("full run: complete");

        // Abort 30 cycles into a run.
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        $display("stop at cycle 30: complete");

        // start and stop together in IDLE, then start re-issued mid-run.
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (70) step(1'b0, 1'b0);
        $display("start/stop overlap and mid-run start: complete");

        // Asynchronous reset between edges at run cycle 42, then a fresh run.
        step(1'b1, 1'b0);
        repeat (42) step(1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        #1 rst = 1'b0;
        step(1'b1, 1'b0);
        repeat (110) step(1'b0, 1'b0);
        $display("async reset mid-run: complete");

        // Random start/stop traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);
        $display("random traffic: complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
